// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared state encoding and index sizing for the multi-precision adder.
`default_nettype none

package mp_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mp_add_sequencer_cla.sv
// ============================================================================
// mp_add_sequencer_cla : single-group carry-lookahead word adder (combinational)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mp_add_sequencer_cla #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             P_i,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;
  logic             w_prop;
  logic             w_cy;

  assign w_g = A_i & B_i;
  assign w_p = A_i ^ B_i;

  // Each carry is a flat sum of generate terms gated by the propagate run above them.
  always_comb begin
    w_c    = '0;
    w_prop = 1'b1;
    w_cy   = 1'b0;
    w_c[0] = P_i;
    for (int i = 0; i < WIDTH; i++) begin
      w_prop = 1'b1;
      w_cy   = 1'b0;
      for (int j = i; j >= 0; j--) begin
        w_cy   = w_cy | (w_g[j] & w_prop);
        w_prop = w_prop & w_p[j];
      end
      w_c[i+1] = w_cy | (w_prop & P_i);
    end
  end

  assign S_o = w_p ^ w_c[WIDTH-1:0];
  assign C_o = w_c[WIDTH];

endmodule

`default_nettype wire

// File: rtl/mp_add_sequencer.sv
// ============================================================================
// mp_add_sequencer : word-serial multi-precision add controller (LSW first)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   CLK_i,
  input  logic                   RST_N_I,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [WIDTH*WORDS-1:0] A_i,
  input  logic [WIDTH*WORDS-1:0] B_i,
  input  logic                   P_i,
  output logic                   ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [WIDTH*WORDS-1:0] S_o,
  output logic                   C_o,
  output logic [WIDTH*WORDS:0]   full_add_o
);

  localparam int IDX_W = idx_w(WORDS);

  state_t                 r_state;
  logic [WIDTH*WORDS-1:0] r_a;
  logic [WIDTH*WORDS-1:0] r_b;
  logic [WIDTH*WORDS-1:0] r_s;
  logic                   r_carry;
  logic                   r_c_out;
  logic [IDX_W-1:0]       r_idx;

  logic [WIDTH-1:0]       w_a_word;
  logic [WIDTH-1:0]       w_b_word;
  logic [WIDTH-1:0]       w_sum;
  logic                   w_cout;

  always_comb begin
    w_a_word = '0;
    w_b_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_word = r_a[i*WIDTH +: WIDTH];
        w_b_word = r_b[i*WIDTH +: WIDTH];
      end
    end
  end

  mp_add_sequencer_cla #(
    .WIDTH (WIDTH)
  ) u_cla (
    .A_i (w_a_word),
    .B_i (w_b_word),
    .P_i (r_carry),
    .S_o (w_sum),
    .C_o (w_cout)
  );

  // r_carry feeds the adder; r_c_out is the visible carry, cleared on accept/abort.
  always_ff @(posedge CLK_i) begin
    if (!RST_N_I) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_a     <= A_i;
            r_b     <= B_i;
            r_carry <= P_i;
            r_s     <= '0;
            r_c_out <= 1'b0;
            r_idx   <= '0;
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (abort_i) begin
            r_s     <= '0;
            r_c_out <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            for (int i = 0; i < WORDS; i++) begin
              if (r_idx == IDX_W'(i)) r_s[i*WIDTH +: WIDTH] <= w_sum;
            end
            r_carry <= w_cout;
            r_c_out <= w_cout;
            r_idx   <= r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(WORDS-1)) r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o    = (r_state == ST_IDLE);
  assign busy_o     = (r_state == ST_ADD);
  assign done_o     = (r_state == ST_DONE);
  assign S_o        = r_s;
  assign C_o        = r_c_out;
  assign full_add_o = {r_c_out, r_s};

endmodule

`default_nettype wire

// File: tb/tb_mp_add_sequencer.sv
// Testbench for mp_add_sequencer: randomized operands against an arithmetic reference.
`default_nettype none

module tb_mp_add_sequencer;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TW = W*N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort, p;
  logic [TW-1:0] a, b;
  logic          ready, busy, done, c;
  logic [TW-1:0] s;
  logic [TW:0]   full;

  logic          start1, p1;
  logic [W-1:0]  a1, b1;
  logic          ready1, busy1, done1, c1;
  logic [W-1:0]  s1;
  logic [W:0]    full1;

  int vectors = 0;
  int miscompares = 0;

  mp_add_sequencer #(.WIDTH(W), .WORDS(N)) dut (
    .CLK_i(clk), .RST_N_I(rst_n), .start_i(start), .abort_i(abort),
    .A_i(a), .B_i(b), .P_i(p),
    .ready_o(ready), .busy_o(busy), .done_o(done),
    .S_o(s), .C_o(c), .full_add_o(full)
  );

  mp_add_sequencer #(.WIDTH(W), .WORDS(1)) dut1 (
    .CLK_i(clk), .RST_N_I(rst_n), .start_i(start1), .abort_i(1'b0),
    .A_i(a1), .B_i(b1), .P_i(p1),
    .ready_o(ready1), .busy_o(busy1), .done_o(done1),
    .S_o(s1), .C_o(c1), .full_add_o(full1)
  );

  function automatic logic [TW:0] ref_add(input logic [TW-1:0] x, input logic [TW-1:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + (TW+1)'(ci);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; p = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; p1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    vectors++;
    if ({ready, busy, done, c, s} !== {1'b1, 1'b0, 1'b0, 1'b0, {TW{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset: ready=%b busy=%b done=%b C=%b S=%h, want 1 0 0 0 0", ready, busy, done, c, s);
    end
    vectors++;
    if ({ready1, busy1, done1, full1} !== {1'b1, 1'b0, 1'b0, 9'h000}) begin
      miscompares++;
      $display("FAIL reset_w1: ready=%b busy=%b done=%b full=%h, want 1 0 0 000", ready1, busy1, done1, full1);
    end
  endtask

  // One full operation; operand inputs are scrambled while busy to prove no resampling.
  task automatic do_op(input logic [TW-1:0] xa, input logic [TW-1:0] xb, input logic xp, input string tag);
    logic [TW:0] exp;
    int n, busy_n;
    logic rdy_bad;
    exp = ref_add(xa, xb, xp);
    a = xa; b = xb; p = xp; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; busy_n = 0; rdy_bad = 1'b0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) busy_n++;
      if (ready !== 1'b0) rdy_bad = 1'b1;
      a = $urandom; b = $urandom; p = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n != N) begin
      miscompares++;
      $display("FAIL %s latency: done after %0d cycles, want %0d", tag, n, N);
    end
    vectors++;
    if (busy_n != N || rdy_bad) begin
      miscompares++;
      $display("FAIL %s busy: busy cycles=%0d ready_high=%b, want %0d and 0", tag, busy_n, rdy_bad, N);
    end
    vectors++;
    if (full !== exp) begin
      miscompares++;
      $display("FAIL %s result: full_add=%h, want %h", tag, full, exp);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || ready !== 1'b1 || full !== exp) begin
      miscompares++;
      $display("FAIL %s after_done: done=%b ready=%b full=%h, want 0 1 %h", tag, done, ready, full, exp);
    end
  endtask

  task automatic test_directed();
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "wrap");
    do_op(32'h1234_5678, 32'h1111_1111, 1'b1, "cin");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "allones");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_back_to_back();
    logic [TW:0] exp_q[$];
    logic [TW:0] e;
    int last_acc, accepts;
    last_acc = -1; accepts = 0;
    start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b spurious_done: full=%h, want no done", full);
        end else begin
          e = exp_q.pop_front();
          if (full !== e) begin
            miscompares++;
            $display("FAIL b2b result: full_add=%h, want %h", full, e);
          end
        end
      end
      a = $urandom; b = $urandom; p = 1'($urandom_range(0, 1));
      if (ready === 1'b1) begin
        if (last_acc >= 0) begin
          vectors++;
          if (cyc - last_acc != N + 2) begin
            miscompares++;
            $display("FAIL b2b interval: %0d cycles, want %0d", cyc - last_acc, N + 2);
          end
        end
        last_acc = cyc;
        accepts++;
        exp_q.push_back(ref_add(a, b, p));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      if (done === 1'b1) begin
        e = exp_q.pop_front();
        vectors++;
        if (full !== e) begin
          miscompares++;
          $display("FAIL b2b drain_result: full_add=%h, want %h", full, e);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (exp_q.size() != 0 || accepts < 6) begin
      miscompares++;
      $display("FAIL b2b completion: pending=%0d accepts=%0d, want 0 and >=6", exp_q.size(), accepts);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    int dones;
    a = $urandom; b = $urandom; p = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    vectors++;
    if ({ready, busy, done, c, s} !== {1'b1, 1'b0, 1'b0, 1'b0, {TW{1'b0}}}) begin
      miscompares++;
      $display("FAIL abort_state: ready=%b busy=%b done=%b C=%b S=%h, want 1 0 0 0 0", ready, busy, done, c, s);
    end
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: %0d done pulses, want 0", dones);
    end
    do_op($urandom, $urandom, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid();
    int dones;
    a = $urandom; b = $urandom; p = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    vectors++;
    if ({ready, busy, done, c, s} !== {1'b1, 1'b0, 1'b0, 1'b0, {TW{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_mid: ready=%b busy=%b done=%b C=%b S=%h, want 1 0 0 0 0", ready, busy, done, c, s);
    end
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_done: %0d done pulses, want 0", dones);
    end
    do_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, "pre_glitch");
    @(posedge clk); #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (full !== 33'h0_1010_1010 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_glitch: full=%h ready=%b, want 010101010 1", full, ready);
    end
  endtask

  task automatic test_single_word();
    logic [W-1:0] xa, xb;
    logic xp;
    logic [W:0] exp;
    int n;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        xa = 8'hFF; xb = 8'h01; xp = 1'b1;
      end else begin
        xa = W'($urandom); xb = W'($urandom); xp = 1'($urandom_range(0, 1));
      end
      exp = {1'b0, xa} + {1'b0, xb} + (W+1)'(xp);
      a1 = xa; b1 = xb; p1 = xp; start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      n = 0;
      while (done1 !== 1'b1 && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      vectors++;
      if (n != 1 || full1 !== exp) begin
        miscompares++;
        $display("FAIL w1_op%0d: latency=%0d full=%h, want 1 and %h", i, n, full1, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_single_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
Multi-precision addition controller. It computes a WORDS*WIDTH-bit sum by running one WIDTH-bit group carry-lookahead adder WORDS times, least significant word first. The carry is held in a register between words. The block sits between a requester (start/ready/done handshake) and the word adder, and owns the operand, result and carry registers plus the sequencing FSM.

Parameters:
WIDTH, 8, bit width of one word (width of the word adder)
WORDS, 4, number of words per operand; legal range >= 1

Ports:
CLK_i  in  1  clock; all state updates on rising edge
RST_N_I  in  1  reset, synchronous, active-low
start_i  in  1  request; accepted only when start_i=1 and ready_o=1 at a rising edge
abort_i  in  1  cancels an operation in progress
A_i  in  WIDTH*WORDS  operand A; sampled only on acceptance
B_i  in  WIDTH*WORDS  operand B; sampled only on acceptance
P_i  in  1  carry-in; sampled only on acceptance
ready_o  out  1  high only in IDLE
busy_o  out  1  high in ADD
done_o  out  1  one-cycle pulse when the result is valid
S_o  out  WIDTH*WORDS  sum; registered
C_o  out  1  final carry-out; registered
full_add_o  out  WIDTH*WORDS+1  {C_o, S_o}

Behaviour:
- Reset: synchronous, active-low, highest priority. State goes to IDLE. A/B/S/carry/index registers are cleared. Outputs after reset: ready_o=1, busy_o=0, done_o=0, S_o=0, C_o=0.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - ready_o=1.
  - On acceptance at edge T: capture A_i, B_i into operand regs and P_i into the carry reg; clear S reg; idx<=0; go to ADD.
  - start_i without acceptance has no effect.
- ADD:
  - The word adder combinationally adds A[idx*WIDTH +: WIDTH], B[idx*WIDTH +: WIDTH] and the carry reg.
  - Each edge: S[idx word] <= sum; carry <= cout; idx <= idx+1.
  - The edge that processes idx==WORDS-1 transitions to DONE.
  - Edges T+1..T+WORDS process words 0..WORDS-1.
- DONE:
  - done_o=1 for exactly the cycle following edge T+WORDS.
  - C_o = final carry. Next state is IDLE.
- Latency: start accepted at edge T -> done_o high from edge T+WORDS to T+WORDS+1. Initiation interval is WORDS+2 cycles when start_i is held high.
- S_o/C_o during ADD show partial values and must not be consumed. After DONE they hold until the next acceptance, which clears S_o and C_o.
- start_i in ADD/DONE: ignored. No queueing, no operand resampling.
- abort_i:
  - Acts only in ADD, at the next edge: go to IDLE, clear S reg and C_o; no done_o pulse.
  - Ignored in IDLE and DONE (a DONE pulse is never suppressed).
  - Priority: reset > abort > sequencing.
- Arithmetic is unsigned modulo 2^(WIDTH*WORDS); the overflow bit is C_o. No X on outputs after the first reset.
- idx width is max(1, $clog2(WORDS)). With WORDS=1, ADD lasts one cycle.

Decomposition:
- Package mp_add_pkg: state enum typedef (IDLE/ADD/DONE), IDX_W localparam function.
- One sub-module: the existing group carry-lookahead word adder, instantiated with WIDTH and used purely combinationally. Its P_i input is driven from the carry reg.
- FSM and registers stay in mp_add_sequencer (~150-250 lines).

Test Plan:
- WIDTH=8, WORDS=4: A=0xFFFFFFFF, B=0x00000001, P=0, start at T -> done_o at T+4..T+5, S_o=0x00000000, C_o=1, full_add_o=0x100000000.
- A=0x12345678, B=0x11111111, P=1 -> S_o=0x2345678A, C_o=0. ready_o=0 from T to DONE; busy_o high exactly 4 cycles.
- start_i held high with new operands each cycle -> accepts every 6 cycles. Operands presented while busy are ignored; each result matches the operands sampled at its own acceptance edge.
- abort_i pulsed at edge T+2 -> IDLE after that edge: ready_o=1, S_o=0, C_o=0, no done_o. A following start completes normally.
- RST_N_I low at edge T+3 mid-ADD -> all outputs at reset values after that edge. An async low pulse between edges has no effect (synchronous check).
- WORDS=1, WIDTH=8: A=0xFF, B=0x01, P=1 -> done_o at T+1..T+2, S_o=0x01, C_o=1.
